matvec_sequencer: RTL

Parametrised control FSM for the matrix-vector multiply datapath. It drives NUM_PROC parallel MAC processors over an n x n matrix, for any n from 1 to N_MAX. Rows are processed in passes of up to NUM_PROC rows, so any n works without changing the FSM structure. It adds FIFO back-pressure stalls, a start/busy/done handshake, abort, and illegal-size detection.

---
 rtl/matvec_sequencer_pkg.sv | 31 +++
 rtl/matvec_sequencer_seq_counter.sv | 35 +++
 rtl/matvec_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/matvec_sequencer_pkg.sv
// Shared definitions for the matrix-vector multiply sequencer: FSM states,
// control bundle driven toward the datapath, and width helpers.
package matvec_sequencer_pkg;

  localparam int unsigned NUM_PROC_MAX = 256;
  localparam int unsigned PROC_IDX_W   = $clog2(NUM_PROC_MAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic                  rst_fifo_in;
    logic                  rst_fifo_out;
    logic                  rst_processor;
    logic                  pop_a_v;
    logic                  push_result;
    logic [PROC_IDX_W-1:0] processor_number;
  } matvec_ctrl_signals_t;

  // Index width for a set of `count` items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/matvec_sequencer_seq_counter.sv
// Up-counter with synchronous clear (dominant over enable) and async
// active-low reset; used for column, drain and pass tracking.
module seq_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (sync_clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/matvec_sequencer.sv
// Control FSM for the matrix-vector multiply datapath: walks an n x n matrix
// in passes of up to NUM_PROC rows, with FIFO stalls, abort and size checking.
module matvec_sequencer
  import matvec_sequencer_pkg::*;
#(
  parameter  int unsigned NUM_PROC = 4,
  parameter  int unsigned N_MAX    = 16,
  localparam int unsigned NW       = $clog2(N_MAX + 1),
  localparam int unsigned PW       = idx_width(NUM_PROC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [NW-1:0] n,
  input  logic          fifo_in_empty,
  input  logic          fifo_out_full,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          rst_fifo_in,
  output logic          rst_fifo_out,
  output logic          rst_processor,
  output logic          pop_a_v,
  output logic          push_result,
  output logic [PW-1:0] processor_number,
  output logic [NW-1:0] pass_index
);

  // Wide enough for n_q and pass*NUM_PROC without overflow.
  localparam int unsigned CW = NW + PW + 1;

  state_e              state_q, state_d;
  logic [NW-1:0]       n_q, n_d;
  logic                error_q, error_d;
  matvec_ctrl_signals_t ctrl_c;

  logic [NW-1:0] col_cnt;
  logic [PW-1:0] drain_cnt;
  logic [NW-1:0] pass_cnt;

  logic [CW-1:0] rows_left;
  logic [CW-1:0] rows_this_pass;
  logic          final_pass;
  logic          pop_c;
  logic          push_c;
  logic          last_pop;
  logic          last_push;
  logic          n_legal;

  assign rows_left      = CW'(n_q) - (CW'(pass_cnt) * CW'(NUM_PROC));
  assign rows_this_pass = (rows_left < CW'(NUM_PROC)) ? rows_left : CW'(NUM_PROC);
  assign final_pass     = (rows_left <= CW'(NUM_PROC));
  assign n_legal        = (n != '0) && (n <= NW'(N_MAX));

  assign pop_c     = (state_q == ST_ACCUM) && !fifo_in_empty;
  assign push_c    = (state_q == ST_DRAIN) && !fifo_out_full;
  assign last_pop  = pop_c && (col_cnt == (n_q - NW'(1)));
  // Full-width compare keeps the terminal check independent of PW.
  assign last_push = push_c &&
                     (ctrl_c.processor_number == PROC_IDX_W'(rows_this_pass - CW'(1)));

  // Next-state, job-size latch and error pulse.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    error_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (n_legal) begin
            n_d     = n;
            state_d = ST_FLUSH;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_FLUSH: state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_ACCUM;
      ST_ACCUM: begin
        if (last_pop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_push) state_d = final_pass ? ST_DONE : ST_CLEAR;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // Moore control decode, with FIFO flags gating pop/push.
  always_comb begin
    ctrl_c = '0;
    unique case (state_q)
      ST_IDLE:  ctrl_c.rst_processor = 1'b1;
      ST_FLUSH: begin
        ctrl_c.rst_fifo_out  = 1'b1;
        ctrl_c.rst_processor = 1'b1;
      end
      ST_CLEAR: ctrl_c.rst_processor = 1'b1;
      ST_ACCUM: ctrl_c.pop_a_v = pop_c;
      ST_DRAIN: begin
        ctrl_c.push_result      = push_c;
        ctrl_c.processor_number = PROC_IDX_W'(drain_cnt);
      end
      ST_DONE:  ctrl_c.rst_fifo_in = 1'b1;
      default:  ctrl_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      error_q <= error_d;
    end
  end

  seq_counter #(.WIDTH(NW)) u_col_cnt (
    .clk        (clk),
    .reset      (reset),
    .enable     (pop_c),
    .sync_clear (state_d != ST_ACCUM),
    .count      (col_cnt)
  );

  seq_counter #(.WIDTH(PW)) u_drain_cnt (
    .clk        (clk),
    .reset      (reset),
    .enable     (push_c),
    .sync_clear (state_d != ST_DRAIN),
    .count      (drain_cnt)
  );

  seq_counter #(.WIDTH(NW)) u_pass_cnt (
    .clk        (clk),
    .reset      (reset),
    .enable     (last_push && !final_pass),
    .sync_clear (state_d == ST_IDLE),
    .count      (pass_cnt)
  );

  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign error            = error_q;
  assign rst_fifo_in      = ctrl_c.rst_fifo_in;
  assign rst_fifo_out     = ctrl_c.rst_fifo_out;
  assign rst_processor    = ctrl_c.rst_processor;
  assign pop_a_v          = ctrl_c.pop_a_v;
  assign push_result      = ctrl_c.push_result;
  assign processor_number = PW'(ctrl_c.processor_number);
  assign pass_index       = pass_cnt;

endmodule
